// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the EX-stage branch resolver: funct3 encodings,
// comparator result bit positions and the BHT counter reset value.
package branch_resolve_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int BR_EQ = 0;
    localparam int BR_LT = 1;
    localparam int BR_GT = 2;

    // Weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        nxt = ctr;
        if (up) begin
            if (ctr != 2'b11) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters: one combinational
// read port for IF, one clocked update port for EX.
module branch_bht
    import branch_resolve_pkg::*;
#(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_VAL = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            assign ctr_d[gi] = (upd_en && (upd_idx == IDX_W'(gi)))
                             ? sat_ctr_next(ctr_q[gi], upd_taken)
                             : ctr_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_VAL;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Reads the pre-update value, so a same-cycle update is seen next cycle.
    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: taken decision, target, mispredict
// redirect and flushes, BHT training and performance counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int         BHT_IDX_W = 6,
    parameter int         CNT_W     = 32,
    parameter logic [1:0] BHT_INIT  = branch_resolve_pkg::BHT_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1_data,
    input  logic [2:0]       branch_result,
    input  logic             ex_ltu,
    input  logic [31:0]      ex_pred_pc,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             cmp_err,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    logic             sel_jalr;
    logic             sel_jal;
    logic             sel_br;
    logic             resolve;
    logic             br_taken;
    logic             f3_legal;
    logic             res_onehot;
    logic             taken;
    logic [31:0]      target;
    logic [31:0]      actual_next;
    logic             br_resolve;
    logic             bht_upd;
    logic [1:0]       if_ctr;

    logic             cmp_err_q, cmp_err_d;
    logic [CNT_W-1:0] perf_branches_q, perf_branches_d;
    logic [CNT_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

    always_comb begin
        sel_jalr = ex_is_jalr;
        sel_jal  = ex_is_jal & ~ex_is_jalr;
        sel_br   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
        resolve  = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jal | ex_is_jalr);

        br_taken = 1'b0;
        f3_legal = 1'b1;
        case (ex_funct3)
            F3_BEQ:  br_taken = branch_result[BR_EQ];
            F3_BNE:  br_taken = ~branch_result[BR_EQ];
            F3_BLT:  br_taken = branch_result[BR_LT];
            F3_BGE:  br_taken = branch_result[BR_EQ] | branch_result[BR_GT];
            F3_BLTU: br_taken = ex_ltu;
            F3_BGEU: br_taken = ~ex_ltu;
            default: f3_legal = 1'b0;
        endcase

        res_onehot = (branch_result == 3'b001) || (branch_result == 3'b010) ||
                     (branch_result == 3'b100);

        taken       = sel_jalr | sel_jal | (sel_br & br_taken);
        target      = sel_jalr ? ((ex_rs1_data + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
        actual_next = taken ? target : (ex_pc + 32'd4);

        redirect_valid = resolve & (actual_next != ex_pred_pc);
        br_resolve     = resolve & sel_br;
        bht_upd        = br_resolve & f3_legal;
    end

    always_comb begin
        cmp_err_d = cmp_err_q | (br_resolve & (~f3_legal | ~res_onehot));

        perf_branches_d = perf_branches_q;
        if (br_resolve && !(&perf_branches_q)) begin
            perf_branches_d = perf_branches_q + CNT_W'(1);
        end

        perf_mispredicts_d = perf_mispredicts_q;
        if (redirect_valid && !(&perf_mispredicts_q)) begin
            perf_mispredicts_d = perf_mispredicts_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_err_q          <= 1'b0;
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            cmp_err_q          <= cmp_err_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    branch_bht #(
        .IDX_W    (BHT_IDX_W),
        .INIT_VAL (BHT_INIT)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_pc[BHT_IDX_W+1:2]),
        .rd_ctr    (if_ctr),
        .upd_en    (bht_upd),
        .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
        .upd_taken (br_taken)
    );

    assign if_pred_taken    = if_ctr[1];
    assign redirect_pc      = actual_next;
    assign flush_if_id      = redirect_valid;
    assign flush_id_ex      = redirect_valid;
    assign cmp_err          = cmp_err_q;
    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios pinned with
// literal expectations, then randomized traffic against a behavioural model.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        if_pred_taken;
    logic        ex_valid = 1'b0, ex_stall = 1'b0;
    logic        ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_pc = '0, ex_imm = '0, ex_rs1_data = '0, ex_pred_pc = '0;
    logic [2:0]  branch_result = 3'b001;
    logic        ex_ltu = 1'b0;
    logic        redirect_valid, flush_if_id, flush_id_ex, cmp_err;
    logic [31:0] redirect_pc, perf_branches, perf_mispredicts;

    always #5 clk = ~clk;

    branch_resolve #(.BHT_IDX_W(6), .CNT_W(32), .BHT_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
        .branch_result(branch_result), .ex_ltu(ex_ltu), .ex_pred_pc(ex_pred_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .cmp_err(cmp_err),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    int checks = 0;
    int passed = 0;

    // Reference state
    bit   [1:0]  m_bht [64];
    logic [31:0] m_pb, m_pm;
    bit          m_err;

    // DUT outputs sampled during the last cycle() call
    logic        obs_rv, obs_pred, obs_err;
    logic [31:0] obs_rpc, obs_pb, obs_pm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_pb  = '0;
        m_pm  = '0;
        m_err = 1'b0;
    endtask

    // What the current EX inputs mean architecturally.
    task automatic model_eval(output bit res, output bit isbr, output bit legal,
                              output bit onehot, output bit tk, output logic [31:0] nxt);
        bit jr, j, eq, lt, gt;
        logic [31:0] tgt;
        jr = ex_is_jalr;
        j  = ex_is_jal && !jr;
        isbr = ex_is_branch && !jr && !j;
        eq = branch_result[0]; lt = branch_result[1]; gt = branch_result[2];
        legal = 1'b1;
        tk = 1'b0;
        if (jr || j) tk = 1'b1;
        case (ex_funct3)
            3'd0: if (isbr) tk = eq;
            3'd1: if (isbr) tk = !eq;
            3'd4: if (isbr) tk = lt;
            3'd5: if (isbr) tk = eq || gt;
            3'd6: if (isbr) tk = ex_ltu;
            3'd7: if (isbr) tk = !ex_ltu;
            default: legal = 1'b0;
        endcase
        tgt = jr ? ((ex_rs1_data + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
        nxt = tk ? tgt : ex_pc + 32'd4;
        res = ex_valid && !ex_stall && (ex_is_branch || ex_is_jal || ex_is_jalr);
        onehot = ($countones(branch_result) == 1);
    endtask

    // One clock: compare at negedge against the model, then advance the model.
    task automatic cycle();
        bit res, isbr, legal, onehot, tk, exp_rv;
        logic [31:0] nxt;
        int idx;
        @(negedge clk);
        model_eval(res, isbr, legal, onehot, tk, nxt);
        exp_rv = res && (nxt != ex_pred_pc);
        obs_rv = redirect_valid; obs_rpc = redirect_pc; obs_pred = if_pred_taken;
        obs_err = cmp_err; obs_pb = perf_branches; obs_pm = perf_mispredicts;
        chk("if_pred_taken", 32'(if_pred_taken), 32'(m_bht[if_pc[7:2]][1]));
        chk("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
        chk("redirect_pc", redirect_pc, nxt);
        chk("flush_if_id", 32'(flush_if_id), 32'(exp_rv));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(exp_rv));
        chk("cmp_err", 32'(cmp_err), 32'(m_err));
        chk("perf_branches", perf_branches, m_pb);
        chk("perf_mispredicts", perf_mispredicts, m_pm);
        @(posedge clk);
        if (res && isbr) begin
            if (m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
            idx = int'(ex_pc[7:2]);
            if (legal) begin
                if (tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
                if (!tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
            end
            if (!legal || !onehot) m_err = 1'b1;
        end
        if (exp_rv && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                          input logic [2:0] res, input logic [31:0] pred);
        ex_valid = 1; ex_stall = 0; ex_is_branch = 1; ex_is_jal = 0; ex_is_jalr = 0;
        ex_pc = pc; ex_imm = imm; ex_funct3 = f3; branch_result = res; ex_pred_pc = pred;
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom % 4)
            0: return 32'h40;
            1: return 32'h14;
            2: return 32'h80;
            default: return {$urandom, 2'b00} >> 0;
        endcase
    endfunction

    initial begin
        model_reset();
        idle();
        if_pc = 32'h40;
        #12;
        chk("reset_pred", 32'(if_pred_taken), 32'd0);
        chk("reset_perf_branches", perf_branches, 32'd0);
        chk("reset_perf_mispredicts", perf_mispredicts, 32'd0);
        chk("reset_cmp_err", 32'(cmp_err), 32'd0);
        chk("reset_redirect", 32'(redirect_valid), 32'd0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // BEQ training at pc 0x40 (BHT index 16)
        set_br(32'h40, 32'h20, 3'b000, 3'b001, 32'h44);
        cycle();
        chk("beq1_rv", 32'(obs_rv), 32'd1);
        chk("beq1_rpc", obs_rpc, 32'h60);
        chk("beq1_pred_old", 32'(obs_pred), 32'd0);
        ex_pred_pc = 32'h60;
        cycle();
        chk("beq2_pred", 32'(obs_pred), 32'd1);
        chk("beq2_perf_mis", obs_pm, 32'd1);
        chk("beq2_rv", 32'(obs_rv), 32'd0);
        cycle();
        set_br(32'h40, 32'h20, 3'b000, 3'b010, 32'h60);
        cycle();
        chk("beq_nt_rv", 32'(obs_rv), 32'd1);
        chk("beq_nt_rpc", obs_rpc, 32'h44);
        ex_pred_pc = 32'h44;
        cycle();
        chk("bht16_10_pred", 32'(obs_pred), 32'd1);
        idle();
        cycle();
        chk("bht16_01_pred", 32'(obs_pred), 32'd0);

        // JALR with odd base
        idle();
        ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h200; ex_rs1_data = 32'h1003;
        ex_imm = 32'h10; ex_pred_pc = 32'h1013;
        cycle();
        chk("jalr_rv", 32'(obs_rv), 32'd1);
        chk("jalr_rpc", obs_rpc, 32'h1012);

        // Stalled mispredicting BGE
        set_br(32'h80, 32'h40, 3'b101, 3'b100, 32'h84);
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_rv", 32'(obs_rv), 32'd0);
        end
        ex_stall = 0;
        cycle();
        chk("stall_release_rv", 32'(obs_rv), 32'd1);
        chk("stall_release_rpc", obs_rpc, 32'hC0);
        idle();
        cycle();
        chk("stall_perf_branches", obs_pb, 32'd6);
        chk("stall_perf_mis", obs_pm, 32'd4);

        // Illegal funct3 -> sticky error
        set_br(32'h100, 32'h8, 3'b010, 3'b001, 32'h104);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();
        chk("illegal_err_sticky", 32'(obs_err), 32'd1);

        // Train BHT[5] to strongly taken, then asynchronous reset mid-cycle
        set_br(32'h14, 32'h8, 3'b000, 3'b001, 32'h1C);
        cycle();
        cycle();
        idle();
        if_pc = 32'h14;
        cycle();
        chk("bht5_pred", 32'(obs_pred), 32'd1);
        #2;
        rst = 1;
        #1;
        chk("async_perf_branches", perf_branches, 32'd0);
        chk("async_perf_mis", perf_mispredicts, 32'd0);
        chk("async_cmp_err", 32'(cmp_err), 32'd0);
        chk("async_bht5_pred", 32'(if_pred_taken), 32'd0);
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Non-one-hot comparator result
        set_br(32'h40, 32'h20, 3'b000, 3'b011, 32'h60);
        cycle();
        idle();
        cycle();
        chk("nonhot_err", 32'(obs_err), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int kind;
            kind = int'($urandom % 10);
            ex_valid = ($urandom % 8) != 0;
            ex_stall = ($urandom % 5) == 0;
            ex_is_branch = (kind <= 5);
            ex_is_jal = (kind == 6);
            ex_is_jalr = (kind == 7);
            if (kind == 8) begin
                ex_is_branch = $urandom % 2; ex_is_jal = $urandom % 2; ex_is_jalr = $urandom % 2;
            end
            if (kind == 9) begin
                ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
            end
            ex_funct3 = 3'($urandom % 8);
            branch_result = (($urandom % 6) == 0) ? 3'($urandom) : 3'(3'b001 << ($urandom % 3));
            ex_ltu = $urandom % 2;
            ex_pc = pick_pc();
            if_pc = pick_pc();
            ex_imm = 32'($urandom_range(0, 511)) * 32'd4 - 32'd1024;
            ex_rs1_data = $urandom;
            case ($urandom % 3)
                0: ex_pred_pc = ex_pc + 32'd4;
                1: ex_pred_pc = ex_pc + ex_imm;
                default: ex_pred_pc = $urandom;
            endcase
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage consumer of the one-hot comparator result {gt, lt, eq}.
- Decides taken/not-taken per funct3 and computes the branch/jump target.
- Checks the IF-stage prediction and issues a redirect plus IF/ID and ID/EX flushes on mispredict.
- Owns the 2-bit saturating branch history table (BHT) that IF reads, plus saturating branch and mispredict performance counters.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries; index is pc[BHT_IDX_W+1:2].
- CNT_W, 32, width of the performance counters.
- BHT_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  32  fetch PC used for the BHT lookup.
- if_pred_taken  out  1  BHT[if_pc index][1].
- ex_valid  in  1  EX holds a real instruction.
- ex_stall  in  1  EX is held this cycle.
- ex_is_branch  in  1  conditional branch.
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_funct3  in  3  branch funct3.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended immediate.
- ex_rs1_data  in  32  forwarded rs1, used by JALR.
- branch_result  in  3  bit0 eq, bit1 signed lt, bit2 signed gt.
- ex_ltu  in  1  unsigned rs1<rs2, for BLTU/BGEU.
- ex_pred_pc  in  32  PC that IF fetched after this instruction.
- redirect_valid  out  1  mispredict; refetch from redirect_pc.
- redirect_pc  out  32  correct next PC.
- flush_if_id  out  1  equals redirect_valid.
- flush_id_ex  out  1  equals redirect_valid.
- cmp_err  out  1  sticky error flag.
- perf_branches  out  CNT_W  resolved conditional branches.
- perf_mispredicts  out  CNT_W  redirects issued.

Behaviour:
- Reset (asynchronous, any time, including mid-stall): every BHT entry = BHT_INIT; perf counters = 0; cmp_err = 0. redirect and flush outputs are combinational, so they read 0 whenever ex_valid = 0.
- resolve = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jal | ex_is_jalr). If more than one type flag is set, priority is jalr > jal > branch.
- Taken by funct3, branch only:
  - 000 BEQ: eq.
  - 001 BNE: ~eq.
  - 100 BLT: lt.
  - 101 BGE: eq | gt.
  - 110 BLTU: ex_ltu.
  - 111 BGEU: ~ex_ltu.
  - 010/011: illegal; treated as not-taken, no BHT update, cmp_err set.
- branch_result not one-hot while an ex_is_branch instruction resolves: cmp_err set; eq/lt/gt are used as given.
- JAL and JALR are always taken.
- Targets, all mod 2^32, wrap silently: branch/JAL = ex_pc + ex_imm; JALR = (ex_rs1_data + ex_imm) & ~32'h1. actual_next = taken ? target : ex_pc + 4.
- Redirect: redirect_valid = resolve & (actual_next != ex_pred_pc). It is combinational in the resolve cycle (zero latency) and lasts exactly one cycle per instruction, because ex_stall suppresses resolve. redirect_pc = actual_next, driven continuously.
- BHT update at the clock edge ending a cycle where resolve & ex_is_branch & legal funct3: counter at ex_pc index increments if taken, else decrements, saturating at 2'b11 / 2'b00. JAL/JALR never update.
- Simultaneous IF lookup and EX update of the same index: IF sees the old value (read-before-write); the new value is visible next cycle.
- A stall spanning many cycles produces exactly one update and one count, in the first non-stalled cycle.
- perf_branches increments on every resolved branch, legal funct3 or not. perf_mispredicts increments on every redirect_valid. Both saturate at all-ones.

Decomposition:
- Shared package: funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU), branch_result bit indices (EQ=0, LT=1, GT=2), BHT_INIT.
- Sub-module branch_bht: BHT_IDX_W-indexed array of 2-bit saturating counters with one combinational read port and one synchronous update port, asynchronous reset to BHT_INIT.

Test Plan:
- Post-reset: if_pc=0x40 -> if_pred_taken=0. BEQ at pc=0x40, imm=0x20, branch_result=001, ex_pred_pc=0x44 -> redirect_valid=1, redirect_pc=0x60, flushes=1, perf_mispredicts=1; next cycle BHT[16]=10.
- Same BEQ taken twice more -> counter 11 then stays 11; if_pred_taken=1. Then not-taken with ex_pred_pc=0x60 -> redirect_pc=0x44, counter 10.
- JALR: rs1=0x1003, imm=0x10, ex_pred_pc=0x1013 -> redirect_pc=0x1012, redirect_valid=1, no BHT change.
- ex_stall=1 for 3 cycles with a mispredicting BGE (result 100) -> no redirect; on release exactly one redirect and perf_branches += 1.
- Illegal funct3 010 or branch_result=011 -> cmp_err=1 and stays 1 until rst pulses.
- Assert rst mid-run after training BHT[5]=11 and perf counters nonzero -> everything cleared immediately without waiting for a clock edge; BHT[5]=01.
